// File: rtl/mux3_rr_sel_arbiter.sv
// Round-robin arbiter driving the s1/s0 select lines of a 3-to-1 mux, with a minimum hold time per grant.
// Optional lock input enabled by defining RR_LOCK_EN.
module mux3_rr_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
`ifdef RR_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_valid;

  logic [1:0] w_rot1;
  logic [1:0] w_rot2;
  logic [1:0] w_win;
  logic       w_req_ptr;
  logic       w_expire;
  logic       w_lock_hold;
  logic       w_decide;

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
    case (idx)
      2'd0:    req_at = r[0];
      2'd1:    req_at = r[1];
      2'd2:    req_at = r[2];
      default: req_at = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Candidates in priority order: ptr+1, ptr+2, then ptr itself (mod 3).
  // NOTE: every signal written in always_comb is assigned a default first so no latch is inferred.
  always_comb begin
    w_rot1    = 2'd0;
    w_rot2    = 2'd1;
    w_req_ptr = 1'b0;
    case (r_ptr)
      2'd0: begin
        w_rot1    = 2'd1;
        w_rot2    = 2'd2;
        w_req_ptr = req[0];
      end
      2'd1: begin
        w_rot1    = 2'd2;
        w_rot2    = 2'd0;
        w_req_ptr = req[1];
      end
      default: begin
        w_rot1    = 2'd0;
        w_rot2    = 2'd1;
        w_req_ptr = req[2];
      end
    endcase
  end

  always_comb begin
    w_win = r_ptr;
    if (req_at(req, w_rot1)) begin
      w_win = w_rot1;
    end else if (req_at(req, w_rot2)) begin
      w_win = w_rot2;
    end
  end

  assign w_expire = (r_cnt == '0) || !w_req_ptr;

`ifdef RR_LOCK_EN
  // Lock only stretches a natural expiry; an early release still goes through.
  assign w_lock_hold = lock && w_req_ptr && (r_cnt == '0);
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_decide = (r_state == ST_IDLE) || (w_expire && !w_lock_hold);

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_sel   <= 2'b11;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 2'd2;
    end else if (w_decide) begin
      if (|req) begin
        r_state <= ST_GRANT;
        r_gnt   <= onehot(w_win);
        r_sel   <= w_win;
        r_valid <= 1'b1;
        r_ptr   <= w_win;
        r_cnt   <= RELOAD;
      end else begin
        r_state <= ST_IDLE;
        r_gnt   <= 3'b000;
        r_sel   <= 2'b11;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign gnt   = r_gnt;
  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = r_valid;

endmodule

// File: tb/tb_mux3_rr_sel_arbiter.sv
// Directed bench for mux3_rr_sel_arbiter (HOLD_CYCLES=4); lock scenario runs when RR_LOCK_EN is defined.
module tb_mux3_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       lock;
  logic [2:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux3_rr_sel_arbiter #(
    .HOLD_CYCLES(4),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
`ifdef RR_LOCK_EN
    .lock (lock),
`endif
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .valid(valid)
  );

  // Advance one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares the packed output bundle {gnt, s1, s0, valid}.
  task automatic check(input string tag, input logic [2:0] e_gnt, input logic [1:0] e_sel,
                       input logic e_valid);
    logic [5:0] obs;
    logic [5:0] exp_v;
    obs   = {gnt, s1, s0, valid};
    exp_v = {e_gnt, e_sel, e_valid};
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed gnt/sel/valid=%b expected %b", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    lock = 1'b0;

    // Reset for two cycles.
    step();
    step();
    check("reset", 3'b000, 2'b11, 1'b0);

    // First grant after reset goes to req0.
    rst = 1'b0;
    req = 3'b001;
    step();
    check("first_gnt", 3'b001, 2'b00, 1'b1);

    // Full load: 001 holds for 4 cycles total, then 010 x4, 100 x4, back to 001.
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_g0", 3'b001, 2'b00, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_g1", 3'b010, 2'b01, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_g2", 3'b100, 2'b10, 1'b1);
    end
    step();
    check("rr_wrap", 3'b001, 2'b00, 1'b1);

    // Early release: req 101 -> 100 during the 2nd cycle of grant 001.
    req = 3'b101;
    step();
    check("hold_2nd", 3'b001, 2'b00, 1'b1);
    req = 3'b100;
    step();
    check("early_rel", 3'b100, 2'b10, 1'b1);

    // Single requester held: grant stays through every reload.
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      step();
      check("single_hold", 3'b010, 2'b01, 1'b1);
    end

    // Reset mid-grant, then priority restarts at req0.
    rst = 1'b1;
    step();
    check("mid_rst", 3'b000, 2'b11, 1'b0);
    rst = 1'b0;
    req = 3'b111;
    step();
    check("post_rst", 3'b001, 2'b00, 1'b1);

    // All requests drop: back to idle with park select.
    req = 3'b000;
    step();
    check("release_idle", 3'b000, 2'b11, 1'b0);
    step();
    check("stay_idle", 3'b000, 2'b11, 1'b0);

    // Reset wins over pending requests.
    req = 3'b111;
    rst = 1'b1;
    step();
    check("rst_over_req", 3'b000, 2'b11, 1'b0);

`ifdef RR_LOCK_EN
    // Lock held: grant 001 persists past expiry; release of lock switches next edge.
    rst  = 1'b0;
    lock = 1'b1;
    req  = 3'b111;
    step();
    check("lock_first", 3'b001, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("lock_hold", 3'b001, 2'b00, 1'b1);
    end
    lock = 1'b0;
    step();
    check("lock_off", 3'b010, 2'b01, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
